// File: rtl/instr_fetch_unit.sv
// Program store plus run FSM that streams one instruction per clock to simple_cpu.
// Build with INSTR_FETCH_LOOP_EN defined to loop the program until start stops it.
module instr_fetch_unit #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     ADDR_BITS   = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [ADDR_BITS-1:0]   load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   load_ready,
    input  logic                   start,
    input  logic                   stall,
    input  logic [ADDR_BITS:0]     prog_len,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   done
);

    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [1:0]             state;
    logic [ADDR_BITS:0]     len;
    logic [ADDR_BITS:0]     count;
    logic [ADDR_BITS:0]     len_clamped;
    logic                   start_ok;
    logic                   last_issue;

    assign load_ready  = (state != RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign start_ok    = start && (prog_len != '0);
    assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign last_issue  = (count == len - 1'b1);

    // Store is deliberately left out of reset so a loaded program survives a reset.
    always_ff @(posedge clk) begin
        if (load_en && load_ready) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            count       <= '0;
            len         <= '0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    instruction <= NOP_WORD;
                    instr_valid <= 1'b0;
                    if (start_ok) begin
                        state <= RUN;
                        len   <= len_clamped;
                        pc    <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
`ifdef INSTR_FETCH_LOOP_EN
                    if (start) begin
                        state       <= DONE;
                        instruction <= NOP_WORD;
                        instr_valid <= 1'b0;
                    end else
`endif
                    if (stall) begin
                        // pc and count hold so the stalled word is issued later, once.
                        instruction <= NOP_WORD;
                        instr_valid <= 1'b0;
                    end else begin
                        instruction <= mem[pc];
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                        count       <= count + 1'b1;
                        if (last_issue) begin
`ifdef INSTR_FETCH_LOOP_EN
                            pc    <= '0;
                            count <= '0;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    instruction <= NOP_WORD;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit with a word-sequence reference model.
// Follows INSTR_FETCH_LOOP_EN to expect looping runs that are stopped by a start pulse.
module tb_instr_fetch_unit;

    localparam logic [19:0] NOP = 20'h00000;
`ifdef INSTR_FETCH_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [19:0] load_data = '0;
    logic        load_ready;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [5:0]  prog_len = '0;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] model_mem [32];

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .stall      (stall),
        .prog_len   (prog_len),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [19:0] data);
        load_en   = 1'b1;
        load_addr = 5'(addr);
        load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // Start a run of plen words and follow it cycle by cycle against the model.
    task automatic run(input int plen, input int stall_pct, input int forced_stall, input bit lock);
        int          eff;
        int          target;
        int          issued;
        int          cyc;
        int          extra;
        int          valid_seen;
        bit          finished;
        bit          st;
        bit          stop_now;
        logic [19:0] ew;
        logic        ev;
        int          epc;
        eff        = (plen > 32) ? 32 : plen;
        target     = LOOP ? 2 * eff : eff;
        issued     = 0;
        cyc        = 0;
        extra      = 0;
        valid_seen = 0;
        finished   = 1'b0;
        prog_len   = 6'(plen);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_pc", 32'(pc), 32'd0);
        check("start_valid", 32'(instr_valid), 32'd0);
        if (lock) begin
            load_en   = 1'b1;
            load_addr = 5'd1;
            load_data = 20'h00001;
        end
        while (extra < 2 && cyc < eff * 8 + 40) begin
            st       = (cyc == forced_stall) || ($urandom_range(0, 99) < stall_pct);
            stall    = st;
            stop_now = LOOP && !finished && (issued == target);
            if (stop_now) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (stop_now) begin
                ew = NOP; ev = 1'b0; finished = 1'b1;
            end else if (!finished && !st) begin
                ew = model_mem[issued % eff]; ev = 1'b1; issued++;
                if (!LOOP && issued == eff) finished = 1'b1;
            end else begin
                ew = NOP; ev = 1'b0;
            end
            epc = LOOP ? (issued % eff) % 32 : issued % 32;
            valid_seen += int'(instr_valid);
            $display("run len=%0d cyc=%0d stall=%0d instr=%05h valid=%0d pc=%0d done=%0d",
                     plen, cyc, st, instruction, instr_valid, pc, done);
            check("instr", 32'(instruction), 32'(ew));
            check("valid", 32'(instr_valid), 32'(ev));
            check("pc", 32'(pc), 32'(epc));
            check("done", 32'(done), 32'(finished));
            check("busy", 32'(busy), 32'(!finished));
            if (lock) check("load_ready", 32'(load_ready), 32'(finished));
            if (finished) begin
                load_en = 1'b0;
                extra++;
            end
            cyc++;
        end
        stall   = 1'b0;
        load_en = 1'b0;
        check("valid_count", 32'(valid_seen), 32'(target));
        check("end_done", 32'(done), 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_instr", 32'(instruction), 32'(NOP));
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #19 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic program, then one stall after word 0, then lockout and rerun.
        load_word(0, 20'h12345);
        load_word(1, 20'h0ABCD);
        load_word(2, 20'hFFFFF);
        run(3, 0, -1, 1'b0);
        run(3, 0, 1, 1'b0);
        run(3, 0, -1, 1'b1);
        run(3, 0, -1, 1'b0);

        // Zero-length start from IDLE does nothing.
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        prog_len = 6'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_done", 32'(done), 32'd0);
        check("len0_valid", 32'(instr_valid), 32'd0);

        // Full store and clamped length.
        for (int i = 0; i < 32; i++) load_word(i, 20'(i));
        run(32, 25, -1, 1'b0);
        run(40, 10, -1, 1'b0);

        // Random programs, lengths and stalls.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) load_word($urandom_range(0, 31), 20'($urandom));
            run($urandom_range(1, 40), 30, -1, 1'b0);
        end

        // Reset in the middle of a run.
        prog_len = 6'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_w0", 32'(instruction), 32'(model_mem[0]));
        @(posedge clk);
        #1;
        check("mid_w1", 32'(instruction), 32'(model_mem[1]));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_instr", 32'(instruction), 32'(NOP));
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_idle_valid", 32'(instr_valid), 32'd0);
        run(5, 20, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction source for simple_cpu. Holds a loadable program store and streams one 20-bit instruction per clock onto the CPU `instruction` input.
- Sits between the testbench/host loader and the CPU. It is the producer end of the CPU's per-cycle instruction interface.
- Provides a load port, a start/stall control and a run FSM. A NOP word is driven whenever no valid instruction is being issued.

Parameters:
- INSTR_WIDTH, 20, instruction word width (matches CPU).
- ADDR_BITS, 5, program store address width (32 words).
- NOP_WORD, 20'h00000, word driven on `instruction` when not issuing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe for the program store.
- load_addr  in  ADDR_BITS  program store write address.
- load_data  in  INSTR_WIDTH  program store write data.
- load_ready  out  1  high when writes are accepted (state != RUN).
- start  in  1  begin run (level sampled on clk).
- stall  in  1  hold PC and issue NOP this cycle.
- prog_len  in  ADDR_BITS+1  number of instructions to issue (1..32).
- instruction  out  INSTR_WIDTH  registered word to CPU.
- instr_valid  out  1  `instruction` carries a program word this cycle.
- pc  out  ADDR_BITS  address of the next word to fetch.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, immediate):
  - state = IDLE, pc = 0, issue count = 0.
  - instruction = NOP_WORD, instr_valid = 0.
  - busy = 0, done = 0, load_ready = 1.
  - Program store contents are not reset.
- Load:
  - If load_en && load_ready at a clk edge, then mem[load_addr] <= load_data.
  - Load writes are ignored while in RUN.
  - Load is legal in IDLE and DONE.
- IDLE/DONE -> RUN:
  - Taken on start=1 with prog_len != 0.
  - Latches len = min(prog_len, 32). pc <= 0, count <= 0.
  - start with prog_len == 0 is ignored; state is unchanged.
- RUN, stall=0, per cycle:
  - instruction <= mem[pc], instr_valid <= 1.
  - pc <= pc + 1 (wraps mod 32), count <= count + 1.
- RUN, stall=1, per cycle:
  - instruction <= NOP_WORD, instr_valid <= 0.
  - pc and count hold, so no word is issued twice.
- Latency:
  - Word 0 appears on `instruction` in the cycle after the start edge.
  - Word k appears k cycles later, plus the number of stall cycles.
- Completion:
  - At the edge that issues word len-1, the FSM moves RUN -> DONE.
  - On the next edge: instruction <= NOP_WORD, instr_valid <= 0.
  - Exactly len valid cycles are issued per run.
- DONE:
  - done = 1, and is held until start re-enters RUN.
  - NOP_WORD is driven continuously.
- start while in RUN is ignored (unless the optional feature is compiled in).
- Simultaneous stall with the final issue: stall wins. The final word is issued on the first unstalled cycle.
- Reset mid-RUN: outputs revert to NOP/invalid immediately, and the CPU sees no partial word.
- Memory read is combinational from mem[pc]; the output register provides the single cycle of latency.

Optional Feature:
- Macro: INSTR_FETCH_LOOP_EN.
- Defined:
  - After issuing word len-1, pc wraps to 0, count resets, and the FSM stays in RUN (continuous program loop).
  - start=1 sampled in RUN acts as stop. The FSM moves to DONE and the next cycle drives NOP_WORD / instr_valid=0.
- Not defined:
  - A run ends in DONE after len words.
  - start is ignored in RUN.

Test Plan:
- Reset then idle:
  - rst pulse -> instruction=20'h00000, instr_valid=0, pc=0, load_ready=1, busy=0, done=0.
  - rst asserted mid-cycle clears the outputs without waiting for a clk edge.
- Load/run:
  - Write mem[0..2] = 20'h12345, 20'h0ABCD, 20'hFFFFF; prog_len=3; start pulse.
  - Expect those three words with instr_valid=1 on cycles 1, 2, 3 after start.
  - Expect done=1 from cycle 3, and NOP from cycle 4.
- Stall:
  - Same program, stall=1 for one cycle after word 0.
  - Expect word 0, then NOP/valid=0, then word 1, then word 2.
  - Expect exactly 3 valid cycles with no duplicate.
- Load lockout:
  - load_en with load_addr=1, load_data=20'h00001 during RUN -> load_ready=0 and mem[1] unchanged.
  - A rerun still issues 20'h0ABCD at slot 1.
- Boundaries:
  - prog_len=0 with start -> stays IDLE.
  - prog_len=32 with mem[i]=i -> 32 valid words 0..31, pc wraps to 0.
  - prog_len=40 is clamped to 32 words.
- Reset mid-RUN:
  - Assert rst after 2 words -> immediate NOP, state IDLE.
  - Re-start reissues from word 0.
  - With INSTR_FETCH_LOOP_EN: prog_len=2 loops 0, 1, 0, 1… until a start pulse, after which done=1.
